// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and widths for the memory bus arbiter: state encoding and bus widths.
package mem_bus_arbiter_pkg;

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned BLOCK_W = 64;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        D_WR = 3'd1,
        D_RD = 3'd2,
        I_RD = 3'd3,
        DMA  = 3'd4
    } arb_state_e;

    function automatic logic is_cpu_xfer(arb_state_e s);
        return (s == D_WR) || (s == D_RD) || (s == I_RD);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_latency_counter.sv
// Loadable down-counter that holds at zero; o_last flags the final cycle of a fixed latency.
module arb_latency_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_last = (r_cnt == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single block-memory port between D-cache, I-cache and a BR/BG DMA master.
// Optional saturating grant/stall statistics are enabled with the ARB_STATS_EN macro.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 4,
    parameter int unsigned STARVE_MAX  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_req,
    input  logic [WORD_W-1:0]  i_addr,
    output logic               i_done,
    output logic [BLOCK_W-1:0] i_rdata,
    input  logic               d_rd_req,
    input  logic               d_wr_req,
    input  logic [WORD_W-1:0]  d_addr,
    input  logic [BLOCK_W-1:0] d_wdata,
    output logic               d_done,
    output logic [BLOCK_W-1:0] d_rdata,
    input  logic               br,
    output logic               bg,
    input  logic               dma_readM,
    input  logic               dma_writeM,
    input  logic [WORD_W-1:0]  dma_address,
    input  logic [BLOCK_W-1:0] dma_wdata,
    output logic               mem_readM,
    output logic               mem_writeM,
    output logic [WORD_W-1:0]  mem_address,
    output logic [BLOCK_W-1:0] mem_wdata,
`ifdef ARB_STATS_EN
    output logic [WORD_W-1:0]  stat_dma_grants,
    output logic [WORD_W-1:0]  stat_cpu_grants,
    output logic [WORD_W-1:0]  stat_stall_cycles,
`endif
    input  logic [BLOCK_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int unsigned SW    = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    arb_state_e         r_state;
    arb_state_e         w_state_next;
    logic               w_grant;
    logic               w_lat_last;
    logic [SW-1:0]      r_starve;
    logic               r_rd;
    logic               r_wr;
    logic               r_bg;
    logic [WORD_W-1:0]  r_addr;
    logic [BLOCK_W-1:0] r_wdata;
    logic [BLOCK_W-1:0] r_i_rdata;
    logic [BLOCK_W-1:0] r_d_rdata;

    assign w_grant = (r_state == IDLE) && (w_state_next != IDLE);

    arb_latency_counter #(
        .CNT_W (CNT_W)
    ) u_lat (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_grant),
        .i_load_val (CNT_W'(MEM_LATENCY - 1)),
        .o_last     (w_lat_last)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: starvation override, then fixed priority d_wr > d_rd > i > br
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (br && (r_starve == SW'(STARVE_MAX))) begin
                    w_state_next = DMA;
                end else if (d_wr_req) begin
                    w_state_next = D_WR;
                end else if (d_rd_req) begin
                    w_state_next = D_RD;
                end else if (i_req) begin
                    w_state_next = I_RD;
                end else if (br) begin
                    w_state_next = DMA;
                end
            end
            D_WR, D_RD, I_RD: begin
                if (w_lat_last) begin
                    w_state_next = IDLE;
                end
            end
            DMA: begin
                if (!br) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Registered strobes, address/data launch, read capture and starvation count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_bg      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_starve  <= '0;
        end else begin
            r_rd <= (w_state_next == D_RD) || (w_state_next == I_RD);
            r_wr <= (w_state_next == D_WR);
            r_bg <= (w_state_next == DMA);

            if (w_grant) begin
                unique case (w_state_next)
                    D_WR: begin
                        r_addr  <= d_addr;
                        r_wdata <= d_wdata;
                    end
                    D_RD: begin
                        r_addr  <= d_addr;
                        r_wdata <= '0;
                    end
                    I_RD: begin
                        r_addr  <= i_addr;
                        r_wdata <= '0;
                    end
                    default: begin
                        r_addr  <= '0;
                        r_wdata <= '0;
                    end
                endcase
            end else if (w_state_next == IDLE) begin
                r_addr  <= '0;
                r_wdata <= '0;
            end

            if ((r_state == I_RD) && w_lat_last) begin
                r_i_rdata <= mem_rdata;
            end
            if ((r_state == D_RD) && w_lat_last) begin
                r_d_rdata <= mem_rdata;
            end

            if (!br || (w_grant && (w_state_next == DMA))) begin
                r_starve <= '0;
            end else if (w_grant && is_cpu_xfer(w_state_next)) begin
                r_starve <= r_starve + SW'(1);
            end
        end
    end

    // Output decode: done pulses on the last latency cycle, DMA passthrough while granted
    always_comb begin
        i_done      = 1'b0;
        d_done      = 1'b0;
        i_rdata     = r_i_rdata;
        d_rdata     = r_d_rdata;
        bg          = r_bg;
        mem_readM   = r_rd;
        mem_writeM  = r_wr;
        mem_address = r_addr;
        mem_wdata   = r_wdata;
        unique case (r_state)
            I_RD: begin
                if (w_lat_last) begin
                    i_done  = 1'b1;
                    i_rdata = mem_rdata;
                end
            end
            D_RD: begin
                if (w_lat_last) begin
                    d_done  = 1'b1;
                    d_rdata = mem_rdata;
                end
            end
            D_WR: begin
                d_done = w_lat_last;
            end
            DMA: begin
                mem_writeM  = dma_writeM;
                mem_readM   = dma_readM && !dma_writeM;
                mem_address = dma_address;
                mem_wdata   = dma_wdata;
            end
            default: ;
        endcase
    end

`ifdef ARB_STATS_EN
    logic [WORD_W-1:0] r_stat_dma;
    logic [WORD_W-1:0] r_stat_cpu;
    logic [WORD_W-1:0] r_stat_stall;

    // Saturating grant and DMA-stall counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_dma   <= '0;
            r_stat_cpu   <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_grant && (w_state_next == DMA) && (r_stat_dma != '1)) begin
                r_stat_dma <= r_stat_dma + WORD_W'(1);
            end
            if (w_grant && is_cpu_xfer(w_state_next) && (r_stat_cpu != '1)) begin
                r_stat_cpu <= r_stat_cpu + WORD_W'(1);
            end
            if ((r_state == DMA) && (i_req || d_rd_req || d_wr_req) && (r_stat_stall != '1)) begin
                r_stat_stall <= r_stat_stall + WORD_W'(1);
            end
        end
    end

    assign stat_dma_grants   = r_stat_dma;
    assign stat_cpu_grants   = r_stat_cpu;
    assign stat_stall_cycles = r_stat_stall;
`endif

endmodule
